// File: rtl/booth_mac_acc8_pkg.sv
// Shared constants and FSM encoding for the Booth multiplier accumulate stage.
package booth_mac_acc8_pkg;

    localparam int PROD_W          = 16;
    localparam int DEF_ACC_WIDTH   = 24;
    localparam int DEF_COUNT_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/booth_mac_sat_add.sv
// Accumulator adder: wraps by default, clamps to the signed range with sat_hit
// when BOOTH_MAC_SAT_EN is defined.
module booth_mac_sat_add
    import booth_mac_acc8_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic [ACC_WIDTH-1:0] a,
    input  logic [ACC_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 sat_hit
);

`ifdef BOOTH_MAC_SAT_EN
    logic [ACC_WIDTH:0] wide;

    assign wide = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};

    // Overflow shows up as the top two bits of the widened sum disagreeing.
    always_comb begin
        sum     = wide[ACC_WIDTH-1:0];
        sat_hit = 1'b0;
        if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
            sat_hit = 1'b1;
            sum     = {wide[ACC_WIDTH], {(ACC_WIDTH-1){~wide[ACC_WIDTH]}}};
        end
    end
`else
    assign sum     = a + b;
    assign sat_hit = 1'b0;
`endif

endmodule

// File: rtl/booth_mac_acc8.sv
// Frame accumulator behind the radix-8 Booth multiplier: sums frame_len products
// into a one-deep valid/ready result register. Optional clamp: BOOTH_MAC_SAT_EN.
module booth_mac_acc8
    import booth_mac_acc8_pkg::*;
#(
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [COUNT_WIDTH-1:0] frame_len,
    input  logic [PROD_W-1:0]      prod_in,
    input  logic                   prod_valid,
    input  logic                   prod_signed,
    output logic [ACC_WIDTH-1:0]   acc_out,
    output logic                   acc_valid,
    input  logic                   acc_ready,
    output logic                   busy,
    output logic                   overrun,
    output logic                   sat
);

    state_t                 state, state_nxt;
    logic [ACC_WIDTH-1:0]   acc;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] len_q;
    logic [COUNT_WIDTH-1:0] len_sel;
    logic [COUNT_WIDTH:0]   len_full;
    logic [COUNT_WIDTH:0]   cnt_inc;
    logic [ACC_WIDTH-1:0]   ext_prod;
    logic [ACC_WIDTH-1:0]   sum;
    logic                   sat_hit;
    logic                   frame_done;

    assign ext_prod = {{(ACC_WIDTH-PROD_W){prod_signed & prod_in[PROD_W-1]}}, prod_in};

    // frame_len is live only for the first product; a zero length means 2^COUNT_WIDTH.
    assign len_sel    = (state == ST_IDLE) ? frame_len : len_q;
    assign len_full   = (len_sel == '0) ? {1'b1, {COUNT_WIDTH{1'b0}}} : {1'b0, len_sel};
    assign cnt_inc    = {1'b0, count} + {{COUNT_WIDTH{1'b0}}, 1'b1};
    assign frame_done = prod_valid && (cnt_inc == len_full);
    assign busy       = (state == ST_ACCUM);

    booth_mac_sat_add #(.ACC_WIDTH(ACC_WIDTH)) u_add (
        .a       (acc),
        .b       (ext_prod),
        .sum     (sum),
        .sat_hit (sat_hit)
    );

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_IDLE;
        end else if (prod_valid) begin
            state_nxt = frame_done ? ST_IDLE : ST_ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // acc_out transfers on any edge with acc_valid & acc_ready; a completion on that
    // same edge refills the register, a completion while stalled is dropped as overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            count     <= '0;
            len_q     <= '0;
            acc_out   <= '0;
            acc_valid <= 1'b0;
            overrun   <= 1'b0;
            sat       <= 1'b0;
        end else begin
            if (acc_valid && acc_ready) begin
                acc_valid <= 1'b0;
            end
            if (clear) begin
                acc     <= '0;
                count   <= '0;
                overrun <= 1'b0;
                sat     <= 1'b0;
            end else if (prod_valid) begin
                if (sat_hit) begin
                    sat <= 1'b1;
                end
                if (state == ST_IDLE) begin
                    len_q <= frame_len;
                end
                if (frame_done) begin
                    acc   <= '0;
                    count <= '0;
                    if (acc_valid && !acc_ready) begin
                        overrun <= 1'b1;
                    end else begin
                        acc_out   <= sum;
                        acc_valid <= 1'b1;
                    end
                end else begin
                    acc   <= sum;
                    count <= cnt_inc[COUNT_WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_mac_acc8.sv
// Bench for booth_mac_acc8 at ACC_WIDTH=17: directed frames plus random traffic
// against an integer-arithmetic frame model; honours BOOTH_MAC_SAT_EN.
module tb_booth_mac_acc8;

    localparam int AW = 17;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic [CW-1:0] frame_len;
    logic [15:0]   prod_in;
    logic          prod_valid;
    logic          prod_signed;
    logic [AW-1:0] acc_out;
    logic          acc_valid;
    logic          acc_ready;
    logic          busy;
    logic          overrun;
    logic          sat;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    booth_mac_acc8 #(.ACC_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .frame_len   (frame_len),
        .prod_in     (prod_in),
        .prod_valid  (prod_valid),
        .prod_signed (prod_signed),
        .acc_out     (acc_out),
        .acc_valid   (acc_valid),
        .acc_ready   (acc_ready),
        .busy        (busy),
        .overrun     (overrun),
        .sat         (sat)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40) begin
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
            end
        end
    endtask

    // behavioural model: real integer sums, folded into AW bits
    longint m_acc, e_out, p, s;
    int     m_n, m_len;
    bit     m_busy, e_valid, e_ovr, e_sat, hit, old_valid;

    function automatic longint fold(input longint x, output bit h);
        longint m, hi, lo, y;
        m  = longint'(1) <<< AW;
        hi = m / 2 - 1;
        lo = -(m / 2);
        h  = 1'b0;
        y  = x;
`ifdef BOOTH_MAC_SAT_EN
        if (y > hi) begin h = 1'b1; y = hi; end
        if (y < lo) begin h = 1'b1; y = lo; end
`else
        y = y % m;
        if (y > hi) y -= m;
        if (y < lo) y += m;
`endif
        return y;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_acc = 0; m_n = 0; m_busy = 0;
            e_out = 0; e_valid = 0; e_ovr = 0; e_sat = 0;
        end else begin
            old_valid = e_valid;
            if (old_valid && acc_ready) e_valid = 0;
            if (clear) begin
                m_acc = 0; m_n = 0; m_busy = 0; e_ovr = 0; e_sat = 0;
            end else if (prod_valid) begin
                if (!m_busy) m_len = (frame_len == 0) ? (1 << CW) : int'(frame_len);
                p = prod_signed ? longint'($signed(prod_in)) : longint'(prod_in);
                s = fold(m_acc + p, hit);
                if (hit) e_sat = 1;
                m_n++;
                if (m_n == m_len) begin
                    if (old_valid && !acc_ready) e_ovr = 1;
                    else begin e_out = s; e_valid = 1; end
                    m_acc = 0; m_n = 0; m_busy = 0;
                end else begin
                    m_acc = s; m_busy = 1;
                end
            end
        end
    end

    // scoreboard compare, every cycle once out of the initial reset
    logic [AW-1:0] exp_out;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_out = e_out[AW-1:0];
            check("acc_out",   longint'(acc_out),   longint'(exp_out));
            check("acc_valid", longint'(acc_valid), longint'(e_valid));
            check("busy",      longint'(busy),      longint'(m_busy));
            check("overrun",   longint'(overrun),   longint'(e_ovr));
            check("sat",       longint'(sat),       longint'(e_sat));
        end
    end

    // driver tasks: start and end just after a falling edge
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [15:0] v);
        prod_in    = v;
        prod_valid = 1'b1;
        @(negedge clk);
        prod_valid = 1'b0;
    endtask

    task automatic drain();
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; frame_len = '0; prod_in = '0;
        prod_valid = 1'b0; prod_signed = 1'b0; acc_ready = 1'b0;
        idle(3);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_acc_out", longint'(acc_out), 0);
        check("reset_busy", longint'(busy), 0);

        // basic signed frame, 2-cycle spacing
        frame_len = 8'd4; prod_signed = 1'b1;
        send(16'd100); idle(1);
        send(16'hFFFD); idle(1);
        send(16'd7); idle(1);
        check("basic_busy", longint'(busy), 1);
        send(16'hFFFF);
        check("basic_sum", longint'(acc_out), 103);
        check("basic_valid", longint'(acc_valid), 1);
        idle(2);
        check("basic_hold", longint'(acc_valid), 1);
        drain();
        check("basic_drained", longint'(acc_valid), 0);

        // single-product frames, back to back, unsigned
        frame_len = 8'd1; prod_signed = 1'b0; acc_ready = 1'b1;
        repeat (3) begin
            send(16'hFFFF);
            check("len1_sum", longint'(acc_out), 65535);
            check("len1_valid", longint'(acc_valid), 1);
        end
        idle(1);
        acc_ready = 1'b0;
        check("len1_drained", longint'(acc_valid), 0);

        // overrun, then completion coinciding with ready
        frame_len = 8'd2; prod_signed = 1'b1;
        send(16'd2); send(16'd3);
        send(16'd4); send(16'd5);
        check("ovr_held", longint'(acc_out), 5);
        check("ovr_flag", longint'(overrun), 1);
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        check("clr_ovr", longint'(overrun), 0);
        check("clr_keeps_valid", longint'(acc_valid), 1);
        send(16'd4);
        acc_ready = 1'b1;
        send(16'd5);
        acc_ready = 1'b0;
        check("swap_sum", longint'(acc_out), 9);
        check("swap_valid", longint'(acc_valid), 1);
        check("swap_no_ovr", longint'(overrun), 0);
        drain();

        // clear mid-frame with a coincident product
        frame_len = 8'd4;
        send(16'd1); send(16'd1);
        clear = 1'b1; prod_in = 16'd1; prod_valid = 1'b1;
        @(negedge clk);
        clear = 1'b0; prod_valid = 1'b0;
        check("clear_busy", longint'(busy), 0);
        repeat (4) send(16'd1);
        check("clear_sum", longint'(acc_out), 4);
        drain();

        // saturation / wrap boundary at 17 bits
        frame_len = 8'd3;
        repeat (3) send(16'h7FFF);
`ifdef BOOTH_MAC_SAT_EN
        check("sat_sum", longint'(acc_out), 65535);
        check("sat_flag", longint'(sat), 1);
`else
        check("wrap_sum", longint'(acc_out), 'h17FFD);
        check("wrap_sat", longint'(sat), 0);
`endif

        // reset with a pending result and a partial frame
        frame_len = 8'd4;
        send(16'd1); send(16'd1);
        check("pre_rst_busy", longint'(busy), 1);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        check("rst_acc_out", longint'(acc_out), 0);
        check("rst_valid", longint'(acc_valid), 0);
        check("rst_busy", longint'(busy), 0);
        frame_len = 8'd2;
        send(16'd7); send(16'd8);
        check("post_rst_sum", longint'(acc_out), 15);
        drain();

        // frame_len 0 means 256 products
        frame_len = 8'd0;
        repeat (255) send(16'd1);
        check("len0_busy", longint'(busy), 1);
        check("len0_not_done", longint'(acc_valid), 0);
        send(16'd1);
        check("len0_sum", longint'(acc_out), 256);
        drain();

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            prod_valid  = ($urandom_range(0, 1) == 1);
            prod_in     = 16'($urandom);
            prod_signed = 1'($urandom_range(0, 1));
            frame_len   = 8'($urandom_range(1, 6));
            acc_ready   = ($urandom_range(0, 3) != 0);
            clear       = ($urandom_range(0, 49) == 0);
            rst         = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        prod_valid = 1'b0; clear = 1'b0; rst = 1'b0; acc_ready = 1'b1;
        idle(3);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
